// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MEM_IDLE_F3 = F3_W;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side access bundle: request fields in, grant and response out.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req;
  logic                  we;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [2:0]            funct3;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_align_chk.sv
// Natural-alignment check for one access; size code 2'b11 is never legal.
module dmem_align_chk (
  input  logic [1:0] addr,
  input  logic [2:0] funct3,
  output logic       aligned
);

  // Sign bit does not affect alignment.
  logic sign_unused_s;
  assign sign_unused_s = funct3[2];

  // Size-dependent low-address test
  always_comb begin
    aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter with dma starvation guard in front of the data memory;
// misaligned accesses are granted but suppressed and answered with err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_arbiter_if.slave         core,
  dmem_arbiter_if.slave         dma,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic              core_aligned_s;
  logic              dma_aligned_s;
  logic              starve_hit_s;
  logic              core_gnt_s;
  logic              dma_gnt_s;
  logic [3:0]        starve_cnt_r;
  owner_e            rsp_owner_r;
  logic              rsp_err_r;
  logic [DATA_W-1:0] core_rdata_r;
  logic [DATA_W-1:0] dma_rdata_r;

  dmem_align_chk u_core_chk (
    .addr    (core.addr[1:0]),
    .funct3  (core.funct3),
    .aligned (core_aligned_s)
  );

  dmem_align_chk u_dma_chk (
    .addr    (dma.addr[1:0]),
    .funct3  (dma.funct3),
    .aligned (dma_aligned_s)
  );

  // Grant decision; reset voids any grant in the same cycle
  always_comb begin
    starve_hit_s = (starve_cnt_r == STARVE_MAX);
    core_gnt_s   = 1'b0;
    dma_gnt_s    = 1'b0;
    if (reset) begin
      core_gnt_s = 1'b0;
      dma_gnt_s  = 1'b0;
    end else if (core.req && dma.req) begin
      if (starve_hit_s) begin
        dma_gnt_s = 1'b1;
      end else begin
        core_gnt_s = 1'b1;
      end
    end else begin
      core_gnt_s = core.req;
      dma_gnt_s  = dma.req;
    end
  end

  assign core.gnt = core_gnt_s;
  assign dma.gnt  = dma_gnt_s;

  // Winner's fields to the memory port; strobes only for aligned accesses
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = {DM_ADDRESS{1'b0}};
    mem_wd     = {DATA_W{1'b0}};
    mem_funct3 = MEM_IDLE_F3;
    if (core_gnt_s) begin
      mem_read   = ~core.we & core_aligned_s;
      mem_write  = core.we & core_aligned_s;
      mem_addr   = core.addr;
      mem_wd     = core.wdata;
      mem_funct3 = core.funct3;
    end else if (dma_gnt_s) begin
      mem_read   = ~dma.we & dma_aligned_s;
      mem_write  = dma.we & dma_aligned_s;
      mem_addr   = dma.addr;
      mem_wd     = dma.wdata;
      mem_funct3 = dma.funct3;
    end else begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
    end
  end

  // Consecutive denied dma cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (!dma.req || dma_gnt_s) begin
      starve_cnt_r <= 4'd0;
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Response capture: loads and errored accesses answer one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_owner_r  <= OWN_NONE;
      rsp_err_r    <= 1'b0;
      core_rdata_r <= {DATA_W{1'b0}};
      dma_rdata_r  <= {DATA_W{1'b0}};
    end else if (core_gnt_s && (!core_aligned_s || !core.we)) begin
      rsp_owner_r  <= OWN_CORE;
      rsp_err_r    <= ~core_aligned_s;
      core_rdata_r <= core_aligned_s ? mem_rd : {DATA_W{1'b0}};
    end else if (dma_gnt_s && (!dma_aligned_s || !dma.we)) begin
      rsp_owner_r  <= OWN_DMA;
      rsp_err_r    <= ~dma_aligned_s;
      dma_rdata_r  <= dma_aligned_s ? mem_rd : {DATA_W{1'b0}};
    end else begin
      rsp_owner_r  <= OWN_NONE;
      rsp_err_r    <= 1'b0;
    end
  end

  assign core.rvalid = (rsp_owner_r == OWN_CORE);
  assign core.err    = (rsp_owner_r == OWN_CORE) & rsp_err_r;
  assign core.rdata  = core_rdata_r;
  assign dma.rvalid  = (rsp_owner_r == OWN_DMA);
  assign dma.err     = (rsp_owner_r == OWN_DMA) & rsp_err_r;
  assign dma.rdata   = dma_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  bit               clk = 1'b0;
  logic             reset;
  logic             mem_read;
  logic             mem_write;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wd;
  logic [2:0]       mem_funct3;
  logic [DW-1:0]    mem_rd;
  logic [31:0]      mem_arr [0:127];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_starve = 0;
  bit          m_c_rv = 1'b0, m_c_err = 1'b0, m_d_rv = 1'b0, m_d_err = 1'b0;
  logic [31:0] m_c_rd = 32'd0, m_d_rd = 32'd0;

  dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) core_if ();
  dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) dma_if ();

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core       (core_if),
    .dma        (dma_if),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_funct3 (mem_funct3),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem_arr[mem_addr[8:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legal when the size code is 0..2 and the address is a multiple of the size.
  function automatic bit ref_ok(input logic [2:0] f3, input logic [8:0] a);
    int sz;
    if (f3[1:0] == 2'd3) return 1'b0;
    sz = 1 << f3[1:0];
    return (int'(a) % sz) == 0;
  endfunction

  task automatic step(input bit rst,
                      input bit creq, input bit cwe, input logic [8:0] cad,
                      input logic [31:0] cwd, input logic [2:0] cf3,
                      input bit dreq, input bit dwe, input logic [8:0] dad,
                      input logic [31:0] dwd, input logic [2:0] df3,
                      output bit gc, output bit gd);
    bit cw, dw, ok, we;
    logic [8:0]  ad;
    logic [31:0] wd;
    logic [2:0]  f3;
    @(negedge clk);
    reset          = rst;
    core_if.req    = creq; core_if.we = cwe; core_if.addr = cad;
    core_if.wdata  = cwd;  core_if.funct3 = cf3;
    dma_if.req     = dreq; dma_if.we = dwe;  dma_if.addr = dad;
    dma_if.wdata   = dwd;  dma_if.funct3 = df3;
    #2;
    cw = 1'b0; dw = 1'b0;
    if (!rst) begin
      if (creq && dreq) begin
        dw = (m_starve >= LIMIT);
        cw = !dw;
      end else begin
        cw = creq;
        dw = dreq;
      end
    end
    ad = 9'd0; wd = 32'd0; f3 = 3'b010; ok = 1'b0; we = 1'b0;
    if (cw) begin
      ad = cad; wd = cwd; f3 = cf3; we = cwe; ok = ref_ok(cf3, cad);
    end else if (dw) begin
      ad = dad; wd = dwd; f3 = df3; we = dwe; ok = ref_ok(df3, dad);
    end
    chk("core_gnt",    32'(core_if.gnt), 32'(cw));
    chk("dma_gnt",     32'(dma_if.gnt),  32'(dw));
    chk("mem_read",    32'(mem_read),    32'((cw | dw) & ok & !we));
    chk("mem_write",   32'(mem_write),   32'((cw | dw) & ok & we));
    chk("mem_addr",    32'(mem_addr),    32'(ad));
    chk("mem_wd",      mem_wd,           wd);
    chk("mem_funct3",  32'(mem_funct3),  32'(f3));
    chk("core_rvalid", 32'(core_if.rvalid), 32'(m_c_rv));
    chk("core_err",    32'(core_if.err),    32'(m_c_err));
    chk("core_rdata",  core_if.rdata,       m_c_rd);
    chk("dma_rvalid",  32'(dma_if.rvalid),  32'(m_d_rv));
    chk("dma_err",     32'(dma_if.err),     32'(m_d_err));
    chk("dma_rdata",   dma_if.rdata,        m_d_rd);
    // Advance the model to the state after this clock edge
    if (rst || !dreq || dw) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (rst) begin
      m_c_rv = 0; m_c_err = 0; m_c_rd = 32'd0;
      m_d_rv = 0; m_d_err = 0; m_d_rd = 32'd0;
    end else begin
      m_c_rv = 0; m_c_err = 0; m_d_rv = 0; m_d_err = 0;
      if (cw && (!ok || !we)) begin
        m_c_rv = 1; m_c_err = !ok; m_c_rd = ok ? mem_arr[ad[8:2]] : 32'd0;
      end
      if (dw && (!ok || !we)) begin
        m_d_rv = 1; m_d_err = !ok; m_d_rd = ok ? mem_arr[ad[8:2]] : 32'd0;
      end
    end
    gc = cw;
    gd = dw;
  endtask

  task automatic idle(input bit rst);
    bit g1, g2;
    step(rst, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, g1, g2);
  endtask

  initial begin
    bit g1, g2;
    bit cp, cwe, dp, dwe, rst;
    logic [8:0]  cad, dad;
    logic [31:0] cwd, dwd;
    logic [2:0]  cf3, df3;
    logic [2:0]  f3tab [0:6];
    f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
    reset = 1'b1;
    core_if.req = 1'b0; core_if.we = 1'b0; core_if.addr = 9'd0;
    core_if.wdata = 32'd0; core_if.funct3 = 3'b000;
    dma_if.req = 1'b0; dma_if.we = 1'b0; dma_if.addr = 9'd0;
    dma_if.wdata = 32'd0; dma_if.funct3 = 3'b000;
    for (int i = 0; i < 128; i++) mem_arr[i] = $urandom;
    mem_arr[4] = 32'hDEAD_BEEF;
    mem_arr[8] = 32'h1234_5678;

    // Reset with requests present
    step(1'b1, 1'b1, 1'b0, 9'h010, 32'd0, 3'b010, 1'b1, 1'b1, 9'h004, 32'd1, 3'b010, g1, g2);
    idle(1'b1);
    idle(1'b0);

    // Core LW aligned
    step(1'b0, 1'b1, 1'b0, 9'h010, 32'd0, 3'b010, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, g1, g2);
    idle(1'b0);

    // Both requesting continuously: four core grants, then dma, then core
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 1'b0, 9'h010, 32'd0, 3'b010, 1'b1, 1'b0, 9'h020, 32'd0, 3'b010, g1, g2);
    idle(1'b0);

    // Misaligned dma SW and core LH
    step(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, 1'b1, 1'b1, 9'h006, 32'h55, 3'b010, g1, g2);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b0, 9'h003, 32'd0, 3'b001, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, g1, g2);
    idle(1'b0);

    // Back-to-back loads from different owners
    step(1'b0, 1'b1, 1'b0, 9'h020, 32'd0, 3'b000, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, g1, g2);
    step(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, 1'b1, 1'b0, 9'h021, 32'd0, 3'b100, g1, g2);
    idle(1'b0);

    // Reset asserted in the grant cycle
    step(1'b1, 1'b1, 1'b0, 9'h010, 32'd0, 3'b010, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, g1, g2);
    idle(1'b0);

    // Store byte then idle
    step(1'b0, 1'b1, 1'b1, 9'h005, 32'h0000_00AB, 3'b000, 1'b0, 1'b0, 9'd0, 32'd0, 3'b000, g1, g2);
    idle(1'b0);

    // Random traffic; requests held until granted
    cp = 1'b0; dp = 1'b0;
    cwe = 1'b0; dwe = 1'b0; cad = 9'd0; dad = 9'd0;
    cwd = 32'd0; dwd = 32'd0; cf3 = 3'b000; df3 = 3'b000;
    for (int n = 0; n < 400; n++) begin
      if (!cp && $urandom_range(0, 9) < 6) begin
        cp = 1'b1; cwe = 1'($urandom_range(0, 1)); cad = 9'($urandom);
        cwd = $urandom; cf3 = f3tab[$urandom_range(0, 6)];
      end
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp = 1'b1; dwe = 1'($urandom_range(0, 1)); dad = 9'($urandom);
        dwd = $urandom; df3 = f3tab[$urandom_range(0, 6)];
      end
      rst = ($urandom_range(0, 49) == 0);
      step(rst, cp, cwe, cad, cwd, cf3, dp, dwe, dad, dwd, df3, g1, g2);
      if (g1) cp = 1'b0;
      if (g2) dp = 1'b0;
    end
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: the pipeline MEM stage (core) and a DMA/loader port (dma).
- Sits between those requesters and the datamemory instance, and drives its MemRead, MemWrite, address, write data and Funct3 inputs.
- Arbitration is core-priority with a starvation counter that guarantees dma forward progress.
- Checks alignment, suppresses misaligned accesses, and returns read data registered, one cycle after the grant.

Parameters:
- DM_ADDRESS, 9, width of the byte address into data memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive denied dma cycles after which dma wins over core; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; held stable until granted.
- core_we  in  1  1=store, 0=load.
- core_addr  in  DM_ADDRESS  byte address.
- core_wdata  in  DATA_W  store data.
- core_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- core_gnt  out  1  access issued this cycle (combinational).
- core_rvalid  out  1  load data or error valid; pulses one cycle after the grant.
- core_rdata  out  DATA_W  registered load data.
- core_err  out  1  misaligned access; qualifies core_rvalid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_funct3, dma_gnt, dma_rvalid, dma_rdata, dma_err: same widths and meaning for the dma port.
- mem_read  out  1  to datamemory MemRead.
- mem_write  out  1  to datamemory MemWrite.
- mem_addr  out  DM_ADDRESS  to datamemory a.
- mem_wd  out  DATA_W  to datamemory wd.
- mem_funct3  out  3  to datamemory Funct3.
- mem_rd  in  DATA_W  from datamemory rd.

Behaviour:
- **Clock and reset.** One clock, clk. Reset is synchronous, active-high, port name reset.
- **Reset values:**
  - rvalid, err and rdata are 0 on both ports.
  - starve_cnt = 0; rsp_owner_q = NONE.
  - gnt = 0 and mem_read = mem_write = 0 while reset is high, even if requests are present.
- **Handshake:**
  - A requester asserts req with stable fields until it sees gnt=1.
  - gnt is combinational, the same cycle as req.
  - Exactly one access issues per cycle. gnt is never asserted without req.
- **Arbitration (when both request):**
  - Only one requester active: it wins.
  - Both active: core wins, unless starve_cnt == STARVE_LIMIT, in which case dma wins.
- **starve_cnt:**
  - +1 on each cycle with dma_req=1 and dma_gnt=0; saturates at STARVE_LIMIT.
  - Cleared on dma_gnt or when dma_req=0.
- **Mux to memory:**
  - Winner's fields drive mem_addr, mem_wd and mem_funct3.
  - mem_read = winner & !we & aligned; mem_write = winner & we & aligned.
  - Idle cycles: mem_addr = 0, mem_wd = 0, mem_funct3 = 3'b010, and mem_read = mem_write = 0.
- **Alignment rule:**
  - Halfword (funct3[1:0]=01) requires addr[0]=0.
  - Word (10) requires addr[1:0]=00.
  - Byte is always aligned.
  - funct3[1:0]=11 is treated as misaligned/illegal.
- **Misaligned access:** still granted (consumes the cycle), but the memory strobes stay 0. The next cycle gives rvalid=1, err=1, rdata=0, for both loads and stores.
- **Response registers:**
  - rsp_owner_q (NONE/CORE/DMA) records the owner of a granted load or an errored access.
  - A good store gives no rvalid.
  - On a good load, mem_rd is sampled at the grant edge into the owner's rdata; rvalid=1 for exactly one cycle.
  - Back-to-back grants give back-to-back rvalid pulses. rdata holds its last value when rvalid=0.
- **Reset mid-operation:** a grant in the cycle where reset is high is void, and any pending rvalid is dropped.
- **Fixed latency:** grant→rvalid is always 1 cycle. There are no outstanding-transaction queues.

Decomposition:
- Shared package dmem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_CORE, OWN_DMA}.
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - MEM_IDLE_F3.
- One sub-module, dmem_align_chk: combinational, inputs addr[1:0] and funct3, output aligned. Instanced once per requester.

Test Plan:
- **Core LW, aligned.** Core LW addr=0x010, memory word 0xDEADBEEF → core_gnt same cycle, mem_read=1, mem_addr=0x010. Next cycle core_rvalid=1, core_rdata=0xDEADBEEF, core_err=0.
- **Both requesting continuously, STARVE_LIMIT=4.** core_req=dma_req=1 held → core granted 4 cycles, dma granted on the 5th, starve_cnt returns to 0, then core wins again.
- **Misaligned accesses.** dma SW addr=0x006 → dma_gnt=1, mem_write=0; next cycle dma_rvalid=1, dma_err=1. Core LH addr=0x003 → core_err=1, mem_read=0.
- **Back-to-back loads.** Core LB 0x020 then dma LBU 0x021 on consecutive cycles → core_rvalid then dma_rvalid on consecutive cycles, each with the correct mem_rd sample and no cross-routing.
- **Reset in grant cycle.** Reset asserted in the cycle of a core LW grant → core_gnt=0, mem_read=0; next cycle core_rvalid=0, rdata=0, starve_cnt=0.
- **Store, then idle.** Core SB addr=0x005, wdata=0xAB → mem_write=1, mem_funct3=000, mem_addr=0x005, no core_rvalid. Following idle cycle: mem_read=mem_write=0, mem_funct3=010.
